// File: rtl/ps2_keycode_source.sv
// PS/2 set-2 keyboard front end: deserialises frames, maps make codes to {valid, ASCII} keycodes.
// Optional macro KEY_FIFO_EN replaces the single holding register with a 2**FIFO_AW-entry key FIFO.
module ps2_keycode_source #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd10000,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FIFO_AW        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    input  logic       keystrobe,
    output logic       frame_err,
    output logic       overrun
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    if (SYNC_STAGES < 2 || FIFO_AW < 1) begin : g_param_check
        $error("ps2_keycode_source: SYNC_STAGES must be >= 2 and FIFO_AW >= 1");
    end

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   strobe_c;
    logic                   bit_c;

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        par_bit;
    logic [15:0] timer;
    logic        ext;
    logic        brk;
    logic        xlat_valid;
    logic [7:0]  xlat_code;
    logic        hit_c;
    logic [6:0]  ascii_c;
    logic        pop_c;

    // Pin synchronisers; idle-high reset value avoids a false edge after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign strobe_c = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign bit_c    = data_sync[SYNC_STAGES-1];

    // Make-code lookup on the fully received byte
    always_comb begin
        hit_c   = 1'b0;
        ascii_c = 7'h00;
        if (ext) begin
            case (shift)
                8'h75: begin hit_c = 1'b1; ascii_c = 7'h77; end
                8'h72: begin hit_c = 1'b1; ascii_c = 7'h73; end
                8'h6B: begin hit_c = 1'b1; ascii_c = 7'h61; end
                8'h74: begin hit_c = 1'b1; ascii_c = 7'h64; end
                default: ;
            endcase
        end else begin
            case (shift)
                8'h1D: begin hit_c = 1'b1; ascii_c = 7'h77; end
                8'h1B: begin hit_c = 1'b1; ascii_c = 7'h73; end
                8'h1C: begin hit_c = 1'b1; ascii_c = 7'h61; end
                8'h23: begin hit_c = 1'b1; ascii_c = 7'h64; end
                8'h29: begin hit_c = 1'b1; ascii_c = 7'h20; end
                8'h5A: begin hit_c = 1'b1; ascii_c = 7'h0D; end
                8'h76: begin hit_c = 1'b1; ascii_c = 7'h1B; end
                default: ;
            endcase
        end
    end

    // Frame receiver, watchdog and prefix (E0/F0) tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            par_bit    <= 1'b0;
            timer      <= 16'd0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            frame_err  <= 1'b0;
            xlat_valid <= 1'b0;
            xlat_code  <= 8'h00;
        end else begin
            frame_err  <= 1'b0;
            xlat_valid <= 1'b0;
            if (state == S_IDLE) begin
                timer <= 16'd0;
                if (strobe_c) begin
                    if (!bit_c) begin
                        state   <= S_DATA;
                        bit_cnt <= 3'd0;
                    end else begin
                        frame_err <= 1'b1;
                        ext       <= 1'b0;
                        brk       <= 1'b0;
                    end
                end
            end else if (strobe_c) begin
                timer <= 16'd0;
                case (state)
                    S_DATA: begin
                        shift   <= {bit_c, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_bit <= bit_c;
                        state   <= S_STOP;
                    end
                    default: begin
                        state <= S_IDLE;
                        if (bit_c && (^{shift, par_bit})) begin
                            if (shift == 8'hE0) begin
                                ext <= 1'b1;
                            end else if (shift == 8'hF0) begin
                                brk <= 1'b1;
                            end else begin
                                xlat_valid <= hit_c & ~brk;
                                xlat_code  <= {1'b1, ascii_c};
                                ext        <= 1'b0;
                                brk        <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                        end
                    end
                endcase
            end else if (timer == TIMEOUT_CYCLES - 16'd1) begin
                state     <= S_IDLE;
                timer     <= 16'd0;
                frame_err <= 1'b1;
                ext       <= 1'b0;
                brk       <= 1'b0;
            end else begin
                timer <= timer + 16'd1;
            end
        end
    end

    assign pop_c = keystrobe & keycode[7];

`ifdef KEY_FIFO_EN
    localparam int unsigned DEPTH = 1 << FIFO_AW;

    logic [7:0]       mem   [DEPTH];
    logic [7:0]       mem_n [DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, wr_n, rd_n;
    logic [7:0]       keycode_n;
    logic             ovf_n;
    logic             full_c;

    assign full_c = (wr_ptr - rd_ptr) == (FIFO_AW+1)'(DEPTH);

    // Next FIFO state; keycode is registered from the next head entry
    always_comb begin
        mem_n = mem;
        wr_n  = wr_ptr;
        rd_n  = rd_ptr;
        ovf_n = 1'b0;
        if (xlat_valid) begin
            if (!full_c || pop_c) begin
                mem_n[wr_ptr[FIFO_AW-1:0]] = xlat_code;
                wr_n = wr_ptr + (FIFO_AW+1)'(1);
            end else begin
                ovf_n = 1'b1;
            end
        end
        if (pop_c) rd_n = rd_ptr + (FIFO_AW+1)'(1);
        keycode_n = (wr_n == rd_n) ? 8'h00 : mem_n[rd_n[FIFO_AW-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'h00;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            keycode <= 8'h00;
            overrun <= 1'b0;
        end else begin
            mem     <= mem_n;
            wr_ptr  <= wr_n;
            rd_ptr  <= rd_n;
            keycode <= keycode_n;
            overrun <= ovf_n;
        end
    end
`else
    // Single holding register; an ack in the same cycle frees room for the new key
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keycode <= 8'h00;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (xlat_valid) begin
                if (!keycode[7] || pop_c) keycode <= xlat_code;
                else                      overrun <= 1'b1;
            end else if (pop_c) begin
                keycode <= 8'h00;
            end
        end
    end
`endif

endmodule
